// File: rtl/fwd_pkg.sv
// -----------------------------------------------------------------------------
// fwd_pkg
// Shared types for the EX-stage forwarding / hazard controller.
//   fwd_sel_e     : operand mux select codes (11 is never produced)
//   stage_slot_t  : shadow copy of one pipeline slot (rd + control flags)
//   BUBBLE        : empty slot; writes nothing, so it never matches a source
//   fwd_pick()    : forwarding decision for one source register
// FWD_RA_W must equal the REG_ADDR_W parameter used by fwd_hazard_ctrl.
// -----------------------------------------------------------------------------
package fwd_pkg;

  localparam int FWD_RA_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic [FWD_RA_W-1:0] rd;
    logic                regwrite;
    logic                is_load;
    logic                is_mdu;
  } stage_slot_t;

  localparam stage_slot_t BUBBLE = '{rd: '0, regwrite: 1'b0, is_load: 1'b0, is_mdu: 1'b0};

  // The producer currently in EX is one stage ahead of the consumer, so when
  // the consumer reaches EX that producer sits in MEM (select 10). A producer
  // currently in MEM will be in WB (select 01). The younger producer wins.
  // x0 is hard-wired zero and is never forwarded.
  function automatic fwd_sel_e fwd_pick(input logic [FWD_RA_W-1:0] rs,
                                        input stage_slot_t         ex,
                                        input stage_slot_t         mem);
    fwd_pick = FWD_RF;
    if (rs != '0) begin
      if (ex.regwrite && (ex.rd == rs)) begin
        fwd_pick = FWD_MEM;
      end else if (mem.regwrite && (mem.rd == rs)) begin
        fwd_pick = FWD_WB;
      end
    end
  endfunction

endpackage

// File: rtl/mdu_hold_ctr.sv
// -----------------------------------------------------------------------------
// mdu_hold_ctr
// Down-counter that keeps a multi-cycle MDU instruction resident in EX.
// Loads MDU_LATENCY-1 when an MDU instruction enters EX and asserts hold
// while non-zero, so the instruction occupies EX for MDU_LATENCY cycles.
// Ports:
//   clk      in  core clock
//   reset_n  in  asynchronous active-low reset (counter cleared)
//   start    in  an MDU instruction is entering EX on this edge
//   hold     out counter non-zero: pipeline must hold
// -----------------------------------------------------------------------------
module mdu_hold_ctr #(
  parameter int MDU_LATENCY = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic hold
);

  localparam int CNT_W = (MDU_LATENCY > 1) ? $clog2(MDU_LATENCY) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MDU_LATENCY - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end else if (start) begin
      // With MDU_LATENCY=1 LOAD_VAL is zero and no hold is ever raised.
      cnt_reg <= LOAD_VAL;
    end
  end

  assign hold = (cnt_reg != '0);

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// fwd_hazard_ctrl
// Forwarding-select and hazard controller for a 5-stage pipeline. Tracks its
// own shadow EX/MEM/WB slots, decides forwarding for the instruction in ID and
// registers the selects so they line up with that instruction in EX.
// Detects load-use hazards (one bubble) and holds the pipeline while an MDU
// operation occupies EX.
//
// Optional feature: define FWD_HAZARD_PERF_CNT_EN to add saturating 32-bit
// counters perf_lu_stalls (load-use bubble cycles) and perf_mdu_stalls (MDU
// hold cycles).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   id_valid                     ID holds a real instruction
//   id_rs1, id_rs2, id_rd        register indices of the ID instruction
//   id_regwrite/is_load/is_mdu   ID instruction control flags
//   fwd_a_sel, fwd_b_sel         registered EX operand mux selects
//   stall_f, stall_d, stall_e    hold PC/IF, IF/ID, ID/EX
//   flush_e                      load a bubble into ID/EX
//   perf_lu_stalls, perf_mdu_stalls  (FWD_HAZARD_PERF_CNT_EN only)
// -----------------------------------------------------------------------------
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int MDU_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_is_load,
  input  logic                  id_is_mdu,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  flush_e
`ifdef FWD_HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]           perf_lu_stalls,
  output logic [31:0]           perf_mdu_stalls
`endif
);

  stage_slot_t ex_slot_reg;
  stage_slot_t mem_slot_reg;
  stage_slot_t wb_slot_reg;
  fwd_sel_e    fwd_a_sel_reg;
  fwd_sel_e    fwd_b_sel_reg;

  stage_slot_t id_slot;
  fwd_sel_e    fwd_a_next;
  fwd_sel_e    fwd_b_next;
  logic        mdu_hold;
  logic        load_use;
  logic        ex_load;
  logic        mdu_start;

  // ---------------------------------------------------------------------------
  // Combinational decisions
  // ---------------------------------------------------------------------------
  always_comb begin
    id_slot    = '{rd: id_rd, regwrite: id_regwrite, is_load: id_is_load, is_mdu: id_is_mdu};
    fwd_a_next = fwd_pick(id_rs1, ex_slot_reg, mem_slot_reg);
    fwd_b_next = fwd_pick(id_rs2, ex_slot_reg, mem_slot_reg);
  end

  // A load in EX cannot forward its data until it reaches MEM, so a consumer
  // directly behind it must wait one cycle.
  assign load_use = id_valid && ex_slot_reg.is_load && ex_slot_reg.regwrite &&
                    (ex_slot_reg.rd != '0) &&
                    ((ex_slot_reg.rd == id_rs1) || (ex_slot_reg.rd == id_rs2));

  // MDU hold dominates: the bubble is suppressed and load-use is simply
  // re-evaluated once the hold drops.
  assign stall_f = mdu_hold | load_use;
  assign stall_d = mdu_hold | load_use;
  assign stall_e = mdu_hold;
  assign flush_e = load_use & ~mdu_hold;

  // stall_d covers both the hold and the load-use bubble, so EX takes a new
  // ID instruction exactly when stall_d is low.
  assign ex_load   = ~stall_d;
  assign mdu_start = ex_load & id_valid & id_is_mdu;

  mdu_hold_ctr #(
    .MDU_LATENCY(MDU_LATENCY)
  ) u_mdu_hold_ctr (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (mdu_start),
    .hold   (mdu_hold)
  );

  // ---------------------------------------------------------------------------
  // Shadow pipeline and registered selects
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_slot_reg   <= BUBBLE;
      mem_slot_reg  <= BUBBLE;
      wb_slot_reg   <= BUBBLE;
      fwd_a_sel_reg <= FWD_RF;
      fwd_b_sel_reg <= FWD_RF;
    end else begin
      wb_slot_reg  <= mem_slot_reg;
      // While EX is held the instruction there has not finished, so nothing
      // advances into MEM.
      mem_slot_reg <= stall_e ? BUBBLE : ex_slot_reg;

      if (stall_e) begin
        // EX slot and selects hold; the MDU latched its operands on entry.
      end else if (flush_e) begin
        ex_slot_reg   <= BUBBLE;
        fwd_a_sel_reg <= FWD_RF;
        fwd_b_sel_reg <= FWD_RF;
      end else if (ex_load) begin
        if (id_valid) begin
          ex_slot_reg   <= id_slot;
          fwd_a_sel_reg <= fwd_a_next;
          fwd_b_sel_reg <= fwd_b_next;
        end else begin
          ex_slot_reg   <= BUBBLE;
          fwd_a_sel_reg <= FWD_RF;
          fwd_b_sel_reg <= FWD_RF;
        end
      end
    end
  end

  assign fwd_a_sel = fwd_a_sel_reg;
  assign fwd_b_sel = fwd_b_sel_reg;

  // The WB slot and some flags are kept for pipeline bookkeeping only; the
  // register file writes through, so nothing downstream consumes them.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{wb_slot_reg, mem_slot_reg.is_load, mem_slot_reg.is_mdu,
                              ex_slot_reg.is_mdu};

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef FWD_HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_lu_stalls  <= '0;
      perf_mdu_stalls <= '0;
    end else begin
      if (flush_e && (perf_lu_stalls != 32'hFFFF_FFFF)) begin
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      end
      if (stall_e && (perf_mdu_stalls != 32'hFFFF_FFFF)) begin
        perf_mdu_stalls <= perf_mdu_stalls + 32'd1;
      end
    end
  end
`else
  // Counters not built.
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       id_is_mdu;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall_f;
  logic       stall_d;
  logic       stall_e;
  logic       flush_e;
`ifdef FWD_HAZARD_PERF_CNT_EN
  logic [31:0] perf_lu_stalls;
  logic [31:0] perf_mdu_stalls;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(
    .REG_ADDR_W (5),
    .MDU_LATENCY(4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_regwrite(id_regwrite),
    .id_is_load (id_is_load),
    .id_is_mdu  (id_is_mdu),
    .fwd_a_sel  (fwd_a_sel),
    .fwd_b_sel  (fwd_b_sel),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .stall_e    (stall_e),
    .flush_e    (flush_e)
`ifdef FWD_HAZARD_PERF_CNT_EN
    ,
    .perf_lu_stalls (perf_lu_stalls),
    .perf_mdu_stalls(perf_mdu_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-18s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic rw, input logic ld, input logic mdu);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    id_is_mdu   = mdu;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    reset_n = 1'b0;
    nop();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fwd_a", fwd_a_sel, 2'b00);
    chk("rst_fwd_b", fwd_b_sel, 2'b00);
    chk("rst_stall_f", stall_f, 1'b0);
    chk("rst_stall_d", stall_d, 1'b0);
    chk("rst_stall_e", stall_e, 1'b0);
    chk("rst_flush_e", flush_e, 1'b0);
    reset_n = 1'b1;
    step();

    // ---------------- add x5 ; add x6,x5,x5 -> 10/10 ----------------
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0);
    #1 chk("b2b_p_stall_f", stall_f, 1'b0);
    step();
    set_id(1, 5'd5, 5'd5, 5'd6, 1, 0, 0);
    #1 chk("b2b_c_stall_f", stall_f, 1'b0);
    chk("b2b_c_flush_e", flush_e, 1'b0);
    step();
    chk("b2b_fwd_a", fwd_a_sel, 2'b10);
    chk("b2b_fwd_b", fwd_b_sel, 2'b10);

    // ---------------- EX producer beats MEM producer ----------------
    drain();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); step();
    set_id(1, 5'd3, 5'd4, 5'd5, 1, 0, 0); step();
    set_id(1, 5'd5, 5'd5, 5'd6, 1, 0, 0); step();
    chk("prio_fwd_a", fwd_a_sel, 2'b10);
    chk("prio_fwd_b", fwd_b_sel, 2'b10);

    // ---------------- add x5 ; add x4 ; sub x7,x4,x5 -> 10/01 ----------------
    drain();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); step();
    set_id(1, 5'd1, 5'd2, 5'd4, 1, 0, 0); step();
    set_id(1, 5'd4, 5'd5, 5'd7, 1, 0, 0); step();
    chk("mix_fwd_a", fwd_a_sel, 2'b10);
    chk("mix_fwd_b", fwd_b_sel, 2'b01);

    // ---------------- add x5 ; nop ; sub x7,x5,x1 -> 01/00 ----------------
    drain();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); step();
    nop(); step();
    set_id(1, 5'd5, 5'd1, 5'd7, 1, 0, 0); step();
    chk("gap_fwd_a", fwd_a_sel, 2'b01);
    chk("gap_fwd_b", fwd_b_sel, 2'b00);

    // ---------------- lw x8 ; add x9,x8,x2 ----------------
    drain();
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 1, 0); step();
    set_id(1, 5'd8, 5'd2, 5'd9, 1, 0, 0);
    #1 chk("lu_stall_f", stall_f, 1'b1);
    chk("lu_stall_d", stall_d, 1'b1);
    chk("lu_flush_e", flush_e, 1'b1);
    chk("lu_stall_e", stall_e, 1'b0);
    step();
    chk("lu_after_stall_f", stall_f, 1'b0);
    chk("lu_after_flush_e", flush_e, 1'b0);
    step();
    chk("lu_fwd_a", fwd_a_sel, 2'b01);
    chk("lu_fwd_b", fwd_b_sel, 2'b00);

    // ---------------- lw x8 ; add x9,x2,x8 (rs2 match) ----------------
    drain();
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 1, 0); step();
    set_id(1, 5'd2, 5'd8, 5'd9, 1, 0, 0);
    #1 chk("lu2_flush_e", flush_e, 1'b1);
    step();
    step();
    chk("lu2_fwd_a", fwd_a_sel, 2'b00);
    chk("lu2_fwd_b", fwd_b_sel, 2'b01);

    // ---------------- lw x8 ; invalid ID reading x8 -> no hazard ----------------
    drain();
    set_id(1, 5'd1, 5'd0, 5'd8, 1, 1, 0); step();
    set_id(0, 5'd8, 5'd8, 5'd9, 1, 0, 0);
    #1 chk("inv_flush_e", flush_e, 1'b0);
    chk("inv_stall_f", stall_f, 1'b0);
    step();

`ifdef FWD_HAZARD_PERF_CNT_EN
    chk("perf_lu", perf_lu_stalls, 32'd2);
`endif

    // ---------------- add x0 ; or x3,x0,x0 -> 00/00 ----------------
    drain();
    set_id(1, 5'd1, 5'd2, 5'd0, 1, 0, 0); step();
    set_id(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    #1 chk("x0_stall_f", stall_f, 1'b0);
    step();
    chk("x0_fwd_a", fwd_a_sel, 2'b00);
    chk("x0_fwd_b", fwd_b_sel, 2'b00);

    // ---------------- lw x0 ; add reading x0 -> no load-use ----------------
    drain();
    set_id(1, 5'd1, 5'd0, 5'd0, 1, 1, 0); step();
    set_id(1, 5'd0, 5'd0, 5'd3, 1, 0, 0);
    #1 chk("lwx0_flush_e", flush_e, 1'b0);
    step();

    // ---------------- add x12 ; mul x10,x12,x2 ; add x11,x10,x10 ----------------
    drain();
    set_id(1, 5'd1, 5'd2, 5'd12, 1, 0, 0); step();
    set_id(1, 5'd12, 5'd2, 5'd10, 1, 0, 1); step();
    set_id(1, 5'd10, 5'd10, 5'd11, 1, 0, 0);
    #1 chk("mdu_h1_stall_e", stall_e, 1'b1);
    chk("mdu_h1_stall_f", stall_f, 1'b1);
    chk("mdu_h1_stall_d", stall_d, 1'b1);
    chk("mdu_h1_flush_e", flush_e, 1'b0);
    chk("mdu_h1_fwd_a", fwd_a_sel, 2'b10);
    step();
    chk("mdu_h2_stall_e", stall_e, 1'b1);
    chk("mdu_h2_fwd_a", fwd_a_sel, 2'b10);
    step();
    chk("mdu_h3_stall_e", stall_e, 1'b1);
    step();
    chk("mdu_rel_stall_e", stall_e, 1'b0);
    chk("mdu_rel_stall_f", stall_f, 1'b0);
    step();
    chk("mdu_dep_fwd_a", fwd_a_sel, 2'b10);
    chk("mdu_dep_fwd_b", fwd_b_sel, 2'b10);
`ifdef FWD_HAZARD_PERF_CNT_EN
    chk("perf_mdu", perf_mdu_stalls, 32'd3);
`endif

    // ---------------- reset mid MDU hold ----------------
    drain();
    set_id(1, 5'd1, 5'd2, 5'd12, 1, 0, 0); step();
    set_id(1, 5'd12, 5'd2, 5'd10, 1, 0, 1); step();
    set_id(1, 5'd10, 5'd12, 5'd13, 1, 0, 0);
    step();
    #1 chk("mid_pre_stall_e", stall_e, 1'b1);
    #1 reset_n = 1'b0;
    #1 chk("mid_rst_stall_e", stall_e, 1'b0);
    chk("mid_rst_stall_f", stall_f, 1'b0);
    chk("mid_rst_fwd_a", fwd_a_sel, 2'b00);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1 chk("post_rst_stall_e", stall_e, 1'b0);
    chk("post_rst_stall_f", stall_f, 1'b0);
    step();
    chk("post_rst_fwd_a", fwd_a_sel, 2'b00);
    chk("post_rst_fwd_b", fwd_b_sel, 2'b00);
`ifdef FWD_HAZARD_PERF_CNT_EN
    chk("post_rst_perf_mdu", perf_mdu_stalls, 32'd0);
    chk("post_rst_perf_lu", perf_lu_stalls, 32'd0);
`endif
    drain();
    set_id(1, 5'd1, 5'd2, 5'd5, 1, 0, 0); step();
    set_id(1, 5'd5, 5'd5, 5'd6, 1, 0, 0); step();
    chk("post_rst_b2b_a", fwd_a_sel, 2'b10);
    chk("post_rst_b2b_b", fwd_b_sel, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Producer side of the EX-stage operand muxes: generates the 2-bit select codes that the 3:1 operand muxes consume, plus pipeline stall and flush controls.
- Keeps its own shadow copy of the destination-register/write-enable/load flags for the EX, MEM and WB slots.
- Decides forwarding for the instruction in ID and registers the selects so they are aligned with that instruction in EX.
- Detects load-use hazards and holds the pipeline while a multi-cycle MDU operation occupies EX.

Parameters:
- REG_ADDR_W, 5, register index width.
- MDU_LATENCY, 4, number of cycles an MDU instruction occupies EX (>=1).

Ports:
- clk  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_regwrite  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- id_is_mdu  in  1  ID instruction is a multi-cycle MDU op.
- fwd_a_sel  out  2  EX operand A mux select (registered).
- fwd_b_sel  out  2  EX operand B mux select (registered).
- stall_f  out  1  hold PC/IF.
- stall_d  out  1  hold the IF/ID register.
- stall_e  out  1  hold the ID/EX register.
- flush_e  out  1  load a bubble into ID/EX.

Behaviour:
- Select encoding:
  - 00 = register-file value.
  - 01 = WB result.
  - 10 = MEM-stage ALU result.
  - 11 is never driven.
- Reset (async, while reset_n=0):
  - all shadow slots are bubbles (regwrite=0).
  - MDU counter = 0.
  - fwd_a_sel = fwd_b_sel = 00.
  - all stall/flush outputs = 0.
- Shadow pipeline, each posedge:
  - WB <= MEM.
  - MEM <= EX, or a bubble if stall_e.
  - EX <= ID fields when !stall_d && !flush_e; a bubble when flush_e; held when stall_e.
- Forward decision is combinational on ID and the current EX/MEM slots, registered into fwd_*_sel when EX loads.
  - If EX.regwrite and EX.rd==rs and rs!=0: select 10 (the producer will be in MEM next cycle).
  - Else if MEM.regwrite and MEM.rd==rs and rs!=0: select 01.
  - Else: select 00.
  - The EX match has priority over the MEM match.
  - A WB-slot producer needs no forwarding: the register file writes through within the cycle.
  - rs==0 always gives 00.
- Load-use hazard: id_valid, EX.is_load, EX.regwrite, EX.rd!=0, and EX.rd equals rs1 or rs2.
  - Response: stall_f=stall_d=flush_e=1 for exactly one cycle.
  - Next cycle the load is in MEM, so the consumer selects 01 on its following entry to EX.
- MDU hold:
  - When an MDU instruction enters EX, the counter loads MDU_LATENCY-1.
  - While counter!=0: stall_f=stall_d=stall_e=1, flush_e=0, counter decrements, MEM receives bubbles.
  - fwd_*_sel hold their values; the MDU latches its operands on its first EX cycle.
  - MDU_LATENCY=1 gives no hold.
- Simultaneous events:
  - MDU hold dominates load-use: flush_e is suppressed, and load-use is re-evaluated on the first cycle after the hold.
  - id_valid=0: no hazard is raised and EX receives a bubble.
- All stall/flush outputs are combinational from registered state plus ID inputs. Latency of a forward decision: 1 cycle (ID to EX).

Optional Feature:
- Macro FWD_HAZARD_PERF_CNT_EN.
- When defined:
  - Adds outputs perf_lu_stalls[31:0] and perf_mdu_stalls[31:0].
  - They count load-use bubble cycles and MDU hold cycles respectively.
  - Both reset to 0, saturate at 0xFFFF_FFFF, and are never cleared except by reset.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Package fwd_pkg:
  - fwd_sel_e enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - stage_slot_t struct: rd, regwrite, is_load, is_mdu.
  - BUBBLE constant of type stage_slot_t.
- One sub-module, mdu_hold_ctr: the down-counter that generates the hold signal, parameterised by MDU_LATENCY.

Test Plan:
- add x5 then add x6,x5,x5 back-to-back -> second instruction in EX sees fwd_a_sel=fwd_b_sel=10; no stall.
- add x5; nop; sub x7,x5,x1 -> sub in EX sees fwd_a_sel=01, fwd_b_sel=00.
- lw x8 then add x9,x8,x2 -> one cycle with stall_f=stall_d=flush_e=1; the add then enters EX with fwd_a_sel=01.
- add x0 then or x3,x0,x0 -> fwd selects 00; no stall.
- mul (MDU_LATENCY=4) followed by a dependent add -> stall_e high for 3 cycles, MEM bubbles, then the add selects 10; with FWD_HAZARD_PERF_CNT_EN, perf_mdu_stalls=3.
- reset_n pulsed low mid MDU hold -> all outputs 0 immediately, counter 0, shadow slots cleared; after release a dependent pair forwards correctly.
